mc14500_seq: RTL and testbench

Program sequencer for the MC14500 ICU in the user project area. It holds the program counter, fetches instruction bytes from a synchronous program ROM, and issues them to the ICU one at a time. It reacts to the ICU's JMP/RTN/FLAG0/FLAGF response pulses to implement jumps, subroutine call/return via a small return stack, and halt.

---
 rtl/mc14500_seq.sv | 145 ++++++++++++++
 tb/tb_mc14500_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc14500_seq.sv
// Program sequencer for the MC14500 ICU: fetches program bytes, strobes them into the ICU and follows its JMP/RTN/FLAG0/FLAGF responses.
// Optional return stack and call tracking are built when MC14500_SEQ_STACK_EN is defined.
module mc14500_seq #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_data,
    output logic [3:0]        icu_instr,
    output logic [3:0]        icu_addr,
    output logic              icu_strobe,
    input  logic              icu_jmp,
    input  logic              icu_rtn,
    input  logic              icu_flag0,
    input  logic              icu_flagf,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, EXEC, RESP, TFETCH, TLOAD, HALT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              do_rtn;

    assign rom_addr = pc;

`ifdef MC14500_SEQ_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack [2**IDX_W];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_m1;
    logic              call_pending;

    assign sp_m1  = sp - 1'b1;
    assign do_rtn = icu_rtn;

    // Return addresses are data only; a dropped push on a full stack leaves them untouched.
    always_ff @(posedge wb_clk_i) begin
        if (state == TLOAD && call_pending && sp != SP_FULL)
            stack[sp[IDX_W-1:0]] <= pc + 1'b1;
    end
`else
    logic unused_resp;
    assign unused_resp = icu_flagf | icu_rtn;
    assign do_rtn      = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = FETCH;
            FETCH:   state_nxt = LATCH;
            LATCH:   state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP: begin
                if (icu_jmp)        state_nxt = TFETCH;
                else if (do_rtn)    state_nxt = FETCH;
                else if (icu_flag0) state_nxt = HALT;
                else if (run)       state_nxt = FETCH;
                else                state_nxt = IDLE;
            end
            TFETCH:  state_nxt = TLOAD;
            TLOAD:   state_nxt = FETCH;
            HALT:    if (!run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            icu_instr  <= 4'h0;
            icu_addr   <= 4'h0;
            rom_rd     <= 1'b0;
            icu_strobe <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
`ifdef MC14500_SEQ_STACK_EN
            sp           <= '0;
            call_pending <= 1'b0;
            err          <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            rom_rd     <= (state_nxt == FETCH) || (state_nxt == TFETCH);
            icu_strobe <= (state_nxt == EXEC);
            busy       <= !((state_nxt == IDLE) || (state_nxt == HALT));
            halted     <= (state_nxt == HALT);

            case (state)
                LATCH: begin
                    icu_instr <= rom_data[7:4];
                    icu_addr  <= rom_data[3:0];
                    pc        <= pc + 1'b1;
                end
`ifdef MC14500_SEQ_STACK_EN
                RESP: begin
                    if (!icu_jmp && icu_rtn) begin
                        if (sp == '0) begin
                            pc  <= '0;
                            err <= 1'b1;
                        end else begin
                            pc <= stack[sp_m1[IDX_W-1:0]];
                            sp <= sp_m1;
                        end
                    end
                end
`endif
                TLOAD: begin
                    pc <= rom_data[ADDR_W-1:0];
`ifdef MC14500_SEQ_STACK_EN
                    if (call_pending) begin
                        if (sp == SP_FULL) err <= 1'b1;
                        else               sp  <= sp + 1'b1;
                    end
`endif
                end
                default: ;
            endcase

`ifdef MC14500_SEQ_STACK_EN
            // A FLAGF seen alongside an RTN arms the next call rather than being lost.
            if (state == TLOAD || (state == RESP && !icu_jmp && icu_rtn))
                call_pending <= 1'b0;
            if (state == RESP && icu_flagf)
                call_pending <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_mc14500_seq.sv
// Directed bench for mc14500_seq with a synchronous ROM model and an ICU model that answers by opcode.
// Expectations follow whether MC14500_SEQ_STACK_EN is defined.
module tb_mc14500_seq;

`ifdef MC14500_SEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       wb_clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] rom_addr;
    logic       rom_rd;
    logic [7:0] rom_data = 8'h00;
    logic [3:0] icu_instr, icu_addr;
    logic       icu_strobe;
    logic       icu_jmp = 1'b0, icu_rtn = 1'b0, icu_flag0 = 1'b0, icu_flagf = 1'b0;
    logic       busy, halted, err;

    logic [7:0] mem [256];
    int cyc = 0;
    int strobe_cnt = 0;
    int strobe_viol = 0;
    logic prev_strobe = 1'b0;
    int last_fetch = 0;
    int errors = 0;
    int checks = 0;

    mc14500_seq #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n), .run(run),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
        .icu_instr(icu_instr), .icu_addr(icu_addr), .icu_strobe(icu_strobe),
        .icu_jmp(icu_jmp), .icu_rtn(icu_rtn), .icu_flag0(icu_flag0), .icu_flagf(icu_flagf),
        .busy(busy), .halted(halted), .err(err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        cyc++;
        if (icu_strobe) strobe_cnt++;
        if (icu_strobe && prev_strobe) strobe_viol++;
        prev_strobe <= icu_strobe;
        if (rom_rd) rom_data <= mem[rom_addr];
        // ICU: 0x0 NOPO->flag0, 0xC JMP, 0xD RTN, 0xF NOPF->flagf
        icu_jmp   <= icu_strobe && (icu_instr == 4'hC);
        icu_rtn   <= icu_strobe && (icu_instr == 4'hD);
        icu_flag0 <= icu_strobe && (icu_instr == 4'h0);
        icu_flagf <= icu_strobe && (icu_instr == 4'hF);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_reset(input logic run_val);
        @(negedge wb_clk_i);
        rst_n = 1'b0;
        run = run_val;
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
    endtask

    task automatic release_reset();
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        run = 1'b1;
    endtask

    task automatic next_fetch(input string tag, input logic [7:0] a, input int gap);
        int n = 0;
        do begin @(negedge wb_clk_i); n++; end while (!rom_rd && n < 40);
        check({tag, "_rd"}, rom_rd, 1);
        check({tag, "_addr"}, rom_addr, a);
        if (gap > 0) check({tag, "_gap"}, cyc - last_fetch, gap);
        last_fetch = cyc;
    endtask

    task automatic wait_addr(input string tag, input logic [7:0] a);
        int n = 0;
        do begin @(negedge wb_clk_i); n++; end while (!(rom_rd && rom_addr == a) && n < 300);
        check({tag, "_reach"}, rom_rd && rom_addr == a, 1);
        last_fetch = cyc;
    endtask

    task automatic exec_check(input string tag, input logic [7:0] b);
        repeat (2) @(negedge wb_clk_i);
        check({tag, "_instr"}, {icu_instr, icu_addr}, b);
        check({tag, "_stb"}, icu_strobe, 1);
        @(negedge wb_clk_i);
        check({tag, "_stb_off"}, icu_strobe, 0);
    endtask

    initial begin
        int base;
        int rd_seen;

        // Reset state with run held high
        hold_reset(1'b1);
        mem[0] = 8'h81; mem[1] = 8'h82; mem[2] = 8'h83;
        repeat (2) @(negedge wb_clk_i);
        check("rst_ctl", {busy, halted, err, rom_rd, icu_strobe}, 5'b0);
        check("rst_addr", rom_addr, 8'h00);
        check("rst_icu", {icu_instr, icu_addr}, 8'h00);
        base = strobe_cnt;
        release_reset();
        next_fetch("a0", 8'h00, 0);
        check("a_busy", busy, 1);
        exec_check("a0", 8'h81);
        next_fetch("a1", 8'h01, 4);
        exec_check("a1", 8'h82);
        next_fetch("a2", 8'h02, 4);
        exec_check("a2", 8'h83);
        check("a_strobes", strobe_cnt - base, 3);

        // Plain jump
        hold_reset(1'b0);
        mem[5] = 8'hC0; mem[6] = 8'h20;
        release_reset();
        wait_addr("b_src", 8'h05);
        next_fetch("b_tf", 8'h06, 4);
        next_fetch("b_tgt", 8'h20, 2);
        next_fetch("b_nxt", 8'h21, 4);
        check("b_err", err, 0);

        // Call and return
        hold_reset(1'b0);
        mem[3] = 8'hF0; mem[4] = 8'hC0; mem[5] = 8'h40; mem[8'h42] = 8'hD0;
        release_reset();
        wait_addr("c_tgt", 8'h40);
        wait_addr("c_rtn", 8'h42);
        next_fetch("c_ret", STK ? 8'h06 : 8'h43, 4);
        check("c_err", err, 0);

        // Five nested calls into a four-entry stack
        hold_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            mem[k * 16]     = 8'hF0;
            mem[k * 16 + 1] = 8'hC0;
            mem[k * 16 + 2] = 8'((k + 1) * 16);
        end
        mem[8'h50] = 8'hD0;
        release_reset();
        wait_addr("d_4th", 8'h40);
        check("d_err4", err, 0);
        wait_addr("d_5th", 8'h50);
        check("d_err5", err, STK);
        next_fetch("d_ret", STK ? 8'h33 : 8'h51, 4);

        // Return with nothing on the stack
        hold_reset(1'b0);
        mem[0] = 8'hD0;
        release_reset();
        next_fetch("u0", 8'h00, 0);
        next_fetch("u_ret", STK ? 8'h00 : 8'h01, 4);
        check("u_err", err, STK);

        // Halt and resume
        hold_reset(1'b0);
        mem[2] = 8'h00;
        release_reset();
        wait_addr("e_nopo", 8'h02);
        repeat (4) @(negedge wb_clk_i);
        check("e_halt", {halted, busy}, 2'b10);
        rd_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge wb_clk_i);
            if (rom_rd) rd_seen++;
        end
        check("e_no_rd", rd_seen, 0);
        check("e_still", halted, 1);
        run = 1'b0;
        @(negedge wb_clk_i);
        check("e_idle", {halted, busy}, 2'b00);
        run = 1'b1;
        next_fetch("e_res", 8'h03, 0);

        // PC wrap, then reset during EXEC
        hold_reset(1'b0);
        mem[0] = 8'hC0; mem[1] = 8'hFF;
        release_reset();
        wait_addr("f_ff", 8'hFF);
        next_fetch("f_wrap", 8'h00, 4);
        repeat (2) @(negedge wb_clk_i);
        check("g_exec", {icu_strobe, rom_addr}, {1'b1, 8'h01});
        rst_n = 1'b0;
        #1;
        check("g_stb", icu_strobe, 0);
        check("g_pc", rom_addr, 8'h00);
        check("g_icu", {icu_instr, icu_addr, busy}, 9'h000);

        check("stb_single", strobe_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
